// File: rtl/aes32_dec_seq_if.sv
// Handshake and control bundle between the AES-32 decryption sequencer and its
// ciphertext source, plaintext consumer and column datapath.
interface aes32_dec_seq_if #(
  parameter int unsigned KAW = 6
) ();
  logic           start;
  logic           in_valid;
  logic           in_ready;
  logic           out_valid;
  logic           out_ready;
  logic [1:0]     ctrl;
  logic [3:0]     round;
  logic [KAW-1:0] key_addr;
  logic           sel_in;
  logic           mix_byp;
  logic           dp_en;
  logic           busy;
  logic           done;

  modport master (
    output start, in_valid, out_ready,
    input  in_ready, out_valid, ctrl, round, key_addr, sel_in, mix_byp, dp_en, busy, done
  );

  modport slave (
    input  start, in_valid, out_ready,
    output in_ready, out_valid, ctrl, round, key_addr, sel_in, mix_byp, dp_en, busy, done
  );
endinterface

// File: rtl/aes32_dec_seq.sv
// Sequencer for a 32-bit/cycle AES decryption datapath: load four ciphertext
// words, run NR rounds of four columns each, then hand out four plaintext words.
module aes32_dec_seq #(
  parameter int unsigned NR  = 10,
  parameter int unsigned KAW = 6
) (
  input logic            clk,
  input logic            rst_n,
  aes32_dec_seq_if.slave bus
);
  typedef enum logic [1:0] {StIdle, StLoad, StRnd, StOut} state_e;

  localparam logic [3:0]  RoundInit = 4'(NR);
  localparam logic [3:0]  RoundLast = 4'(NR - 1);
  localparam int unsigned AddrW     = (KAW > 6) ? KAW : 6;

  state_e     state_q, state_d;
  logic [1:0] ctrl_q, ctrl_d;
  logic [3:0] round_q, round_d;
  logic       done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ctrl_q  <= 2'd0;
      round_q <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      round_q <= round_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    round_d = round_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StLoad;
          ctrl_d  = 2'd0;
          round_d = RoundInit;
        end
      end
      StLoad: begin
        if (bus.in_valid) begin
          ctrl_d = ctrl_q + 2'd1;
          if (ctrl_q == 2'd3) begin
            state_d = StRnd;
            round_d = RoundLast;
          end
        end
      end
      StRnd: begin
        // Column counter wraps 3->0; the round counter steps on each wrap.
        ctrl_d = ctrl_q + 2'd1;
        if (ctrl_q == 2'd3) begin
          if (round_q == 4'd0) begin
            state_d = StOut;
          end else begin
            round_d = round_q - 4'd1;
          end
        end
      end
      StOut: begin
        if (bus.out_ready) begin
          ctrl_d = ctrl_q + 2'd1;
          if (ctrl_q == 2'd3) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
    endcase
  end

  logic [AddrW-1:0] addr_full;
  assign addr_full = AddrW'({round_q, ctrl_q});

  assign bus.ctrl      = ctrl_q;
  assign bus.round     = round_q;
  assign bus.key_addr  = addr_full[KAW-1:0];
  assign bus.in_ready  = (state_q == StLoad);
  assign bus.sel_in    = (state_q == StLoad);
  assign bus.out_valid = (state_q == StOut);
  assign bus.mix_byp   = (state_q == StRnd) && (round_q == 4'd0);
  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = done_q;
  // The datapath must capture on the same edge the handshake completes.
  assign bus.dp_en     = ((state_q == StLoad) && bus.in_valid) || (state_q == StRnd) ||
                         ((state_q == StOut) && bus.out_ready);
endmodule

// File: tb/tb_aes32_dec_seq.sv
// Scoreboard bench: two sequencers (NR=10 and NR=14) share randomized stimulus;
// each expected control trace is generated from the round schedule and checked.
module tb_aes32_dec_seq;
  typedef struct packed {
    logic [1:0] ctrl;
    logic [3:0] round;
    logic [5:0] key_addr;
    logic       sel_in;
    logic       mix_byp;
    logic       in_ready;
    logic       out_valid;
    logic       busy;
    logic       done;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n;
  logic start, in_valid, out_ready;
  int   n_cmp = 0;
  int   n_bad = 0;
  obs_t q10[$];
  obs_t q14[$];

  always #5 clk = ~clk;

  aes32_dec_seq_if #(.KAW(6)) bus10 ();
  aes32_dec_seq_if #(.KAW(6)) bus14 ();

  assign bus10.start     = start;
  assign bus10.in_valid  = in_valid;
  assign bus10.out_ready = out_ready;
  assign bus14.start     = start;
  assign bus14.in_valid  = in_valid;
  assign bus14.out_ready = out_ready;

  aes32_dec_seq #(.NR(10), .KAW(6)) dut10 (.clk(clk), .rst_n(rst_n), .bus(bus10));
  aes32_dec_seq #(.NR(14), .KAW(6)) dut14 (.clk(clk), .rst_n(rst_n), .bus(bus14));

  function automatic obs_t mk(input int c, input int r, input bit si, input bit mb,
                              input bit ir, input bit ov, input bit b, input bit d);
    obs_t o;
    o.ctrl      = 2'(c);
    o.round     = 4'(r);
    o.key_addr  = 6'(r * 4 + c);
    o.sel_in    = si;
    o.mix_byp   = mb;
    o.in_ready  = ir;
    o.out_valid = ov;
    o.busy      = b;
    o.done      = d;
    return o;
  endfunction

  function automatic void push(input bit which, input obs_t o);
    if (which) q14.push_back(o);
    else       q10.push_back(o);
  endfunction

  // Expected trace of one decryption: one entry per datapath-enabled cycle, then DONE.
  function automatic void push_op(input int nr, input bit which);
    for (int i = 0; i < 4; i++) push(which, mk(i, nr, 1, 0, 1, 0, 1, 0));
    for (int r = nr - 1; r >= 0; r--)
      for (int c = 0; c < 4; c++) push(which, mk(c, r, 0, (r == 0), 0, 0, 1, 0));
    for (int i = 0; i < 4; i++) push(which, mk(i, 0, 0, 0, 0, 1, 1, 0));
    push(which, mk(0, 0, 0, 0, 0, 0, 0, 1));
  endfunction

  function automatic obs_t get_act(input bit which);
    obs_t a;
    a.ctrl      = which ? bus14.ctrl      : bus10.ctrl;
    a.round     = which ? bus14.round     : bus10.round;
    a.key_addr  = which ? bus14.key_addr  : bus10.key_addr;
    a.sel_in    = which ? bus14.sel_in    : bus10.sel_in;
    a.mix_byp   = which ? bus14.mix_byp   : bus10.mix_byp;
    a.in_ready  = which ? bus14.in_ready  : bus10.in_ready;
    a.out_valid = which ? bus14.out_valid : bus10.out_valid;
    a.busy      = which ? bus14.busy      : bus10.busy;
    a.done      = which ? bus14.done      : bus10.done;
    return a;
  endfunction

  function automatic logic get_dp(input bit which);
    return which ? bus14.dp_en : bus10.dp_en;
  endfunction

  // While busy the outputs must equal the pending head entry (stalls hold it).
  task automatic check_one(input bit which);
    obs_t act, head;
    logic exp_dp;
    int   qs;
    act = get_act(which);
    qs  = which ? q14.size() : q10.size();
    if (act.busy || act.done) begin
      if (qs == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_activity nr%0d: got %h want idle", which ? 14 : 10, act);
      end else begin
        head   = which ? q14[0] : q10[0];
        exp_dp = head.in_ready ? in_valid : (head.out_valid ? out_ready : head.busy);
        n_cmp++;
        if (act !== head) begin
          n_bad++;
          $display("FAIL trace nr%0d: got %h want %h", which ? 14 : 10, act, head);
        end
        n_cmp++;
        if (get_dp(which) !== exp_dp) begin
          n_bad++;
          $display("FAIL dp_en nr%0d: got %b want %b", which ? 14 : 10, get_dp(which), exp_dp);
        end
        if (exp_dp || head.done) begin
          if (which) void'(q14.pop_front());
          else       void'(q10.pop_front());
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check_one(1'b0);
      check_one(1'b1);
    end
  end

  task automatic check_zero(input bit which, input string tag);
    obs_t act;
    act = get_act(which);
    n_cmp++;
    if (act !== '0 || get_dp(which) !== 1'b0) begin
      n_bad++;
      $display("FAIL %s nr%0d: got %h dp %b want 0", tag, which ? 14 : 10, act, get_dp(which));
    end
  endtask

  task automatic check_val(input string tag, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  task automatic run_op(input bit nostall);
    int first_ov = -1;
    int done_cyc = -1;
    int cyc      = 0;
    in_valid  = 1'($urandom_range(0, 1));
    out_ready = 1'b1;
    start     = 1'b1;
    push_op(10, 1'b0);
    push_op(14, 1'b1);
    @(posedge clk); #1;
    while (cyc < 2000 && (q10.size() != 0 || q14.size() != 0)) begin
      if (bus10.out_valid && first_ov < 0) first_ov = cyc;
      if (bus10.done) done_cyc = cyc;
      in_valid  = nostall ? 1'b1 : 1'($urandom_range(0, 3) != 0);
      out_ready = nostall ? 1'b1 : 1'($urandom_range(0, 2) != 0);
      start     = (!nostall && bus10.busy && bus14.busy) ? 1'($urandom_range(0, 3) == 0) : 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    if (q10.size() != 0 || q14.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout: pending %0d/%0d want 0/0", q10.size(), q14.size());
      q10.delete();
      q14.delete();
    end
    if (nostall) begin
      check_val("first_out_valid_cycle", first_ov, 44);
      check_val("done_cycle", done_cyc, 48);
    end
  endtask

  initial begin
    int guard;
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #10;
    check_zero(1'b0, "reset_state");
    check_zero(1'b1, "reset_state");
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(1'b1);
    for (int op = 0; op < 10; op++) run_op(1'b0);

    // Abort mid-RND at round 5 with an asynchronous reset.
    start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    push_op(10, 1'b0);
    push_op(14, 1'b1);
    @(posedge clk); #1 start = 1'b0;
    guard = 0;
    while (guard < 200 && !(bus10.busy && !bus10.in_ready && !bus10.out_valid &&
                            bus10.round == 4'd5)) begin
      @(posedge clk); #1;
      guard++;
    end
    check_val("reached_round5", int'(bus10.round), 5);
    rst_n = 1'b0;
    #1;
    check_zero(1'b0, "async_abort");
    check_zero(1'b1, "async_abort");
    q10.delete();
    q14.delete();
    @(posedge clk); #1;
    check_zero(1'b0, "held_in_reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(1'b0);
    run_op(1'b1);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
